// File: rtl/nano_mem_responder_if.sv
// CPU-side memory bus of the NanoCPU: word address, write data, strobes and
// combinational read data.
interface nano_mem_responder_if;
  logic [7:0]  address;
  logic [15:0] dataW;
  logic [15:0] dataR;
  logic        ce;
  logic        we;

  modport master (output address, dataW, ce, we, input dataR);
  modport slave  (input address, dataW, ce, we, output dataR);
endinterface

// File: rtl/nano_mem_responder.sv
// 256x16 RAM responder for NanoCPU with byte-stream program loader and two
// memory-mapped I/O words (output register with strobe, input port).
module nano_mem_responder #(
  parameter logic [7:0] OUT_ADDR = 8'hFF,
  parameter logic [7:0] IN_ADDR  = 8'hFE
) (
  input  logic                  ck,
  input  logic                  rst,
  nano_mem_responder_if.slave   bus,
  input  logic                  ld_start,
  input  logic [7:0]            ld_words,
  input  logic [7:0]            ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  cpu_hold,
  output logic                  load_done,
  input  logic [15:0]           io_in,
  output logic [15:0]           io_out,
  output logic                  io_strobe
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD_HI = 2'd1;
  localparam logic [1:0] LOAD_LO = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state;
  logic [8:0]  ptr, count;
  logic [7:0]  hi;
  logic [15:0] mem [256];

  logic        cpu_wr, ld_fire, ld_wr, ram_we, last_word;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data;

  assign ld_ready  = (state == LOAD_HI) || (state == LOAD_LO);
  assign cpu_hold  = (state != IDLE);
  assign load_done = (state == DONE);

  assign cpu_wr    = bus.ce & bus.we & ~cpu_hold;
  assign ld_fire   = ld_valid & ld_ready;
  assign ld_wr     = ld_fire & (state == LOAD_LO);
  assign last_word = (ptr + 9'd1) == count;

  // Loader and CPU never write together: CPU writes are masked by cpu_hold.
  assign ram_we   = ld_wr | (cpu_wr & (bus.address != OUT_ADDR) & (bus.address != IN_ADDR));
  assign ram_addr = ld_wr ? ptr[7:0] : bus.address;
  assign ram_data = ld_wr ? {hi, ld_data} : bus.dataW;

  always_ff @(posedge ck) begin
    if (ram_we) mem[ram_addr] <= ram_data;
  end

  always_comb begin
    bus.dataR = 16'h0000;
    if (bus.ce && !cpu_hold) begin
      if (bus.address == IN_ADDR)       bus.dataR = io_in;
      else if (bus.address == OUT_ADDR) bus.dataR = io_out;
      else                              bus.dataR = mem[bus.address];
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      hi        <= '0;
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= cpu_wr && (bus.address == OUT_ADDR);
      if (cpu_wr && (bus.address == OUT_ADDR)) io_out <= bus.dataW;

      case (state)
        IDLE: if (ld_start) begin
          // A word count of zero means a full 256-word image.
          count <= (ld_words == 8'd0) ? 9'd256 : {1'b0, ld_words};
          ptr   <= '0;
          state <= LOAD_HI;
        end
        LOAD_HI: if (ld_fire) begin
          hi    <= ld_data;
          state <= LOAD_LO;
        end
        LOAD_LO: if (ld_fire) begin
          ptr   <= ptr + 9'd1;
          state <= last_word ? DONE : LOAD_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nano_mem_responder.sv
// Directed bench for nano_mem_responder: loader, stall, CPU access, MMIO,
// 256-word load and reset mid-load.
module tb_nano_mem_responder;
  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        ld_start = 1'b0, ld_valid = 1'b0;
  logic [7:0]  ld_words = '0, ld_data = '0;
  logic        ld_ready, cpu_hold, load_done, io_strobe;
  logic [15:0] io_in = '0, io_out;
  int          n_chk = 0, n_err = 0;

  nano_mem_responder_if bus();

  nano_mem_responder dut (
    .ck(ck), .rst(rst), .bus(bus),
    .ld_start(ld_start), .ld_words(ld_words), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .cpu_hold(cpu_hold),
    .load_done(load_done), .io_in(io_in), .io_out(io_out), .io_strobe(io_strobe)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ld_data  = b;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    bus.ce = 1'b1; bus.we = 1'b0; bus.address = a;
    #1;
    chk(tag, bus.dataR, exp);
    bus.ce = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus.ce = 1'b1; bus.we = 1'b1; bus.address = a; bus.dataW = d;
    tick();
    bus.we = 1'b0; bus.ce = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bus.ce = 1'b0; bus.we = 1'b0; bus.address = '0; bus.dataW = '0;

    // Reset state
    tick(); tick();
    chk("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
    chk("rst_cpu_hold", {15'd0, cpu_hold}, 16'd0);
    chk("rst_load_done", {15'd0, load_done}, 16'd0);
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst_io_strobe", {15'd0, io_strobe}, 16'd0);
    chk("rst_dataR_ce0", bus.dataR, 16'h0000);
    rst = 1'b0;
    tick();

    // 3-word load
    ld_start = 1'b1; ld_words = 8'd3;
    tick();
    ld_start = 1'b0;
    chk("ld3_hold", {15'd0, cpu_hold}, 16'd1);
    chk("ld3_ready", {15'd0, ld_ready}, 16'd1);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h9A);
    chk("ld3_no_done_early", {15'd0, load_done}, 16'd0);
    send(8'hBC);
    chk("ld3_done", {15'd0, load_done}, 16'd1);
    chk("ld3_done_hold", {15'd0, cpu_hold}, 16'd1);
    tick();
    chk("ld3_done_pulse", {15'd0, load_done}, 16'd0);
    chk("ld3_release", {15'd0, cpu_hold}, 16'd0);
    chk("ld3_ready_off", {15'd0, ld_ready}, 16'd0);
    rd("ld3_m0", 8'h00, 16'h1234);
    rd("ld3_m1", 8'h01, 16'h5678);
    rd("ld3_m2", 8'h02, 16'h9ABC);

    // 1-word load, ld_valid together with ld_start must not be consumed; stall mid-word
    ld_start = 1'b1; ld_words = 8'd1; ld_valid = 1'b1; ld_data = 8'h11;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    send(8'hDE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ready", {15'd0, ld_ready}, 16'd1);
    end
    chk("stall_no_done", {15'd0, load_done}, 16'd0);
    send(8'hAD);
    chk("stall_done", {15'd0, load_done}, 16'd1);
    tick();
    rd("stall_m0", 8'h00, 16'hDEAD);
    rd("stall_m1", 8'h01, 16'h5678);

    // CPU write then read next cycle
    wr(8'h10, 16'hBEEF);
    rd("cpu_rd", 8'h10, 16'hBEEF);
    bus.ce = 1'b0; bus.address = 8'h10;
    #1 chk("cpu_ce0", bus.dataR, 16'h0000);

    // MMIO
    wr(8'hFF, 16'h00A5);
    chk("mmio_out", io_out, 16'h00A5);
    chk("mmio_strobe", {15'd0, io_strobe}, 16'd1);
    tick();
    chk("mmio_strobe_1cyc", {15'd0, io_strobe}, 16'd0);
    rd("mmio_rd_ff", 8'hFF, 16'h00A5);
    io_in = 16'h1234;
    rd("mmio_rd_fe", 8'hFE, 16'h1234);
    wr(8'hFE, 16'h5555);
    chk("mmio_fe_out", io_out, 16'h00A5);
    chk("mmio_fe_strobe", {15'd0, io_strobe}, 16'd0);
    rd("mmio_fe_rd", 8'hFE, 16'h1234);
    rd("mmio_fe_ram", 8'h10, 16'hBEEF);

    // 256-word load with CPU write and second ld_start attempted mid-load
    ld_start = 1'b1; ld_words = 8'd0;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (i == 20) begin
        bus.ce = 1'b1; bus.we = 1'b1; bus.address = 8'h05; bus.dataW = 16'hFFFF;
        #1 chk("full_hold_dataR", bus.dataR, 16'h0000);
      end
      if (i == 100) begin ld_start = 1'b1; ld_words = 8'd2; end
      send(b);
      bus.ce = 1'b0; bus.we = 1'b0; ld_start = 1'b0;
      if (i == 255) chk("full_no_done_early", {15'd0, load_done}, 16'd0);
      send(~b);
    end
    chk("full_done", {15'd0, load_done}, 16'd1);
    tick();
    chk("full_release", {15'd0, cpu_hold}, 16'd0);
    for (int a = 0; a < 254; a++) begin
      b = 8'(a);
      rd("full_mem", b, {b, ~b});
    end

    // Reset after 1.5 words
    ld_start = 1'b1; ld_words = 8'd4;
    tick();
    ld_start = 1'b0;
    send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    #1;
    chk("rstmid_hold", {15'd0, cpu_hold}, 16'd0);
    chk("rstmid_ready", {15'd0, ld_ready}, 16'd0);
    chk("rstmid_io_out", io_out, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    rd("rstmid_m0", 8'h00, 16'h1122);
    rd("rstmid_m1", 8'h01, 16'h01FE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/nano_mem_responder.md
Name: nano_mem_responder

Overview:
- Memory-side responder for the NanoCPU memory interface: 256 x 16-bit RAM serving the CPU's address, dataR, dataW, ce and we signals.
- Includes a byte-stream program loader that fills RAM from address 0 while holding the CPU in reset (cpu_hold).
- Includes two memory-mapped I/O words: an output register with a strobe, and an input port.

Parameters:
- OUT_ADDR, 8'hFF, address of the memory-mapped output register.
- IN_ADDR, 8'hFE, address of the memory-mapped input port (read-only).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- address  in  8  CPU word address.
- dataW  in  16  CPU write data.
- ce  in  1  CPU chip enable.
- we  in  1  CPU write enable (qualified by ce).
- dataR  out  16  read data to CPU, combinational.
- ld_start  in  1  one-cycle pulse: begin a program load.
- ld_words  in  8  number of words to load; 0 means 256.
- ld_data  in  8  loader byte, high byte of each word first.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  responder accepts a byte this cycle.
- cpu_hold  out  1  CPU reset request while loading.
- load_done  out  1  one-cycle pulse when the last word is written.
- io_in  in  16  input port value.
- io_out  out  16  output register.
- io_strobe  out  1  one-cycle pulse after each OUT_ADDR write.

Behaviour:
- Reset values: state=IDLE; ld_ready=0, cpu_hold=0, load_done=0, io_out=16'h0000, io_strobe=0; word counter=0. RAM contents are not cleared (undefined until written).
- Read path is combinational, zero latency:
  - ce=0 or cpu_hold=1 -> dataR=16'h0000.
  - address==IN_ADDR -> dataR=io_in.
  - address==OUT_ADDR -> dataR=io_out.
  - otherwise -> dataR=mem[address].
- CPU write: at the rising edge when ce & we & ~cpu_hold.
  - address==OUT_ADDR: io_out<=dataW; io_strobe=1 the next cycle only.
  - address==IN_ADDR: write dropped.
  - otherwise: mem[address]<=dataW.
- Loader FSM states: IDLE, LOAD_HI, LOAD_LO, DONE.
  - IDLE: ld_start=1 -> capture count (0 -> 256, counter width 9 bits), clear word pointer, go to LOAD_HI.
  - LOAD_HI: ld_ready=1; on ld_valid latch ld_data as hi byte, go to LOAD_LO.
  - LOAD_LO: ld_ready=1; on ld_valid write mem[ptr]={hi,ld_data}, ptr+1; go to DONE if this was the last word, else LOAD_HI.
  - DONE: load_done=1 for exactly one cycle, then IDLE.
  - A byte transfers only when ld_valid & ld_ready; ld_valid=0 stalls indefinitely with no timeout.
- cpu_hold=1 in LOAD_HI, LOAD_LO and DONE; 0 in IDLE. The CPU restarts from PC=0 the cycle after DONE.
- ld_start outside IDLE is ignored. ld_start and ld_valid in the same IDLE cycle: the byte is not consumed.
- Loader writes land at addresses 0..N-1 regardless of OUT_ADDR/IN_ADDR. A 256-word load writes RAM at FE/FF, but those locations are not CPU-visible.
- CPU writes during the load are dropped. There is no RAM write-port conflict, since CPU writes are blocked while cpu_hold=1.
- rst mid-load: the FSM returns to IDLE immediately and cpu_hold drops. Already-written words stay in RAM; partial hi-byte data is discarded.
- A write followed by a read of the same address in the next cycle returns the new data.

Test Plan:
- Load 3 words: ld_words=3, byte stream 12 34 56 78 9A BC -> mem[0..2]=1234,5678,9ABC. cpu_hold=1 from the cycle after ld_start; load_done pulses once; then cpu_hold=0 and ld_ready=0.
- Loader stall: ld_valid deasserted for 5 cycles between hi and lo bytes -> state holds at LOAD_LO, no RAM write, then the word completes correctly.
- CPU access: ce=1, we=1, address=8'h10, dataW=16'hBEEF -> next cycle ce=1, we=0, address=8'h10 gives dataR=BEEF; ce=0 gives dataR=0000.
- MMIO: write 16'h00A5 to FF -> io_out=00A5 and io_strobe high for exactly 1 cycle; read FF returns 00A5. io_in=16'h1234, read FE returns 1234. Write to FE leaves RAM and io_out unchanged.
- Boundary: ld_words=0 -> exactly 256 words (512 bytes) loaded before load_done. CPU writes attempted during the load do not alter RAM. A second ld_start mid-load is ignored.
- Reset mid-load: rst after 1.5 words -> cpu_hold=0, ld_ready=0, io_out=0 immediately; mem[0] retains the loaded word.
